// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation is in flight at a time: accept (IDLE), execute (EXEC), respond (RESP).
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_in1,
  input  logic [DATA_W-1:0] req0_in2,
  input  logic [3:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_in1,
  input  logic [DATA_W-1:0] req1_in2,
  input  logic [3:0]        req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_out,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_out,
  output logic              rsp1_zero,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_alucon,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] in1_p0, in2_p0;
  logic [3:0]        op_p0;
  logic              win_p0;
  logic [DATA_W-1:0] res_p1;
  logic              zero_p1;
  logic              prio_q;
  logic              grant;
  logic              accept;
  logic              rsp_done;
  logic              vld_p2;

  always_comb begin
    state_d    = state_q;
    grant      = prio_q;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // Nothing is granted while rst is high, even though state already reads IDLE.
        if (!rst && (req0_valid || req1_valid)) begin
          grant      = (req0_valid && req1_valid) ? prio_q : req1_valid;
          accept     = 1'b1;
          req0_ready = !grant;
          req1_ready = grant;
          state_d    = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_done = win_p0 ? rsp1_ready : rsp0_ready;
        if (rsp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      in1_p0  <= '0;
      in2_p0  <= '0;
      op_p0   <= '0;
      win_p0  <= 1'b0;
      res_p1  <= '0;
      zero_p1 <= 1'b0;
    end else begin
      state_q <= state_d;
      // Stage 0: operand capture from the granted requester
      if (accept) begin
        in1_p0 <= grant ? req1_in1 : req0_in1;
        in2_p0 <= grant ? req1_in2 : req0_in2;
        op_p0  <= grant ? req1_op  : req0_op;
        win_p0 <= grant;
      end
      // Stage 1: ALU result capture
      if (state_q == EXEC) begin
        res_p1  <= alu_out;
        zero_p1 <= alu_zero;
      end
      // The pointer moves only once a response completes; the loser gets next contention.
      if (rsp_done) prio_q <= ~win_p0;
    end
  end

  assign alu_in1    = in1_p0;
  assign alu_in2    = in2_p0;
  assign alu_alucon = op_p0;

  // Stage 2: response presentation
  assign vld_p2     = (state_q == RESP);
  assign rsp0_valid = vld_p2 && !win_p0;
  assign rsp1_valid = vld_p2 && win_p0;
  assign rsp0_out   = rsp0_valid ? res_p1 : '0;
  assign rsp0_zero  = rsp0_valid ? zero_p1 : 1'b0;
  assign rsp1_out   = rsp1_valid ? res_p1 : '0;
  assign rsp1_zero  = rsp1_valid ? zero_p1 : 1'b0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU attached.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0] rsp0_out, rsp1_out;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_alucon;
  logic        alu_zero;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1),
    .req0_in2(req0_in2), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1),
    .req1_in2(req1_in2), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_out(rsp0_out),
    .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_out(rsp1_out),
    .rsp1_zero(rsp1_zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_alucon(alu_alucon),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  // Shared ALU
  always_comb begin
    alu_out = 32'd0;
    case (alu_alucon)
      4'd0:  alu_out = alu_in1 + alu_in2;
      4'd8:  alu_out = alu_in1 - alu_in2;
      4'd1:  alu_out = alu_in1 << alu_in2[4:0];
      4'd2:  alu_out = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
      4'd3:  alu_out = {31'd0, alu_in1 < alu_in2};
      4'd4:  alu_out = alu_in1 ^ alu_in2;
      4'd5:  alu_out = alu_in1 >> alu_in2[4:0];
      4'd13: alu_out = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
      4'd6:  alu_out = alu_in1 | alu_in2;
      4'd7:  alu_out = alu_in1 & alu_in2;
      default: alu_out = 32'd0;
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here, checks follow #1 later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_in1 = 0; req0_in2 = 0; req0_op = 0;
    req1_valid = 0; req1_in1 = 0; req1_in2 = 0; req1_op = 0;
    rsp0_ready = 1; rsp1_ready = 1;

    // Reset: a request during reset is not accepted
    step(); step();
    req0_valid = 1; req0_in1 = 5; req0_in2 = 7; req0_op = 0;
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_alu_in1", alu_in1, 0);
    chk("rst_alu_op", alu_alucon, 0);

    // Single ADD 5+7
    rst = 0; #1;
    chk("add_req0_ready_T", req0_ready, 1);
    chk("add_req1_ready_T", req1_ready, 0);
    chk("add_rsp0_valid_T", rsp0_valid, 0);
    step(); req0_valid = 0; #1;
    chk("add_req0_ready_T1", req0_ready, 0);
    chk("add_alu_in1", alu_in1, 5);
    chk("add_alu_in2", alu_in2, 7);
    chk("add_rsp0_valid_T1", rsp0_valid, 0);
    step(); #1;
    chk("add_rsp0_valid_T2", rsp0_valid, 1);
    chk("add_rsp0_out", rsp0_out, 12);
    chk("add_rsp0_zero", rsp0_zero, 0);
    chk("add_rsp1_valid_T2", rsp1_valid, 0);
    step(); #1;
    chk("add_rsp0_valid_T3", rsp0_valid, 0);
    chk("add_rsp0_out_idle", rsp0_out, 0);

    // Contention after reset: SUB 3-3 vs AND 0xF0&0x0F
    rst = 1; step(); rst = 0;
    req0_valid = 1; req0_in1 = 3; req0_in2 = 3; req0_op = 8;
    req1_valid = 1; req1_in1 = 32'hF0; req1_in2 = 32'h0F; req1_op = 7;
    #1;
    chk("c1_req0_ready", req0_ready, 1);
    chk("c1_req1_ready", req1_ready, 0);
    step(); req0_valid = 0; #1;
    chk("c1_exec_req1_ready", req1_ready, 0);
    step(); #1;
    chk("c1_rsp0_valid", rsp0_valid, 1);
    chk("c1_rsp0_out", rsp0_out, 0);
    chk("c1_rsp0_zero", rsp0_zero, 1);
    chk("c1_rsp1_valid", rsp1_valid, 0);
    chk("c1_no_accept_on_rsp", req1_ready, 0);
    step(); req0_valid = 1; #1;
    chk("c2_req1_ready", req1_ready, 1);
    chk("c2_req0_ready", req0_ready, 0);
    step(); req1_in1 = 1; req1_in2 = 2; req1_op = 6; #1;
    step(); #1;
    chk("c2_rsp1_valid", rsp1_valid, 1);
    chk("c2_rsp1_out", rsp1_out, 0);
    chk("c2_rsp1_zero", rsp1_zero, 1);
    chk("c2_rsp0_valid", rsp0_valid, 0);
    step(); #1;
    chk("c3_req0_ready", req0_ready, 1);
    chk("c3_req1_ready", req1_ready, 0);
    step(); req0_valid = 0; #1;
    step(); #1;
    chk("c3_rsp0_out", rsp0_out, 0);
    chk("c3_rsp0_zero", rsp0_zero, 1);
    step(); #1;
    chk("or_req1_ready", req1_ready, 1);
    step(); req1_valid = 0; #1;
    step(); #1;
    chk("or_rsp1_out", rsp1_out, 3);
    chk("or_rsp1_zero", rsp1_zero, 0);

    // Backpressure: SRA 0x80000000 >>> 4 with rsp1_ready low
    step();
    req1_valid = 1; req1_in1 = 32'h8000_0000; req1_in2 = 4; req1_op = 13;
    #1;
    chk("bp_req1_ready", req1_ready, 1);
    step();
    req1_valid = 0; rsp1_ready = 0;
    req0_valid = 1; req0_in1 = 1; req0_in2 = 1; req0_op = 0;
    #1;
    chk("bp_exec_req0_ready", req0_ready, 0);
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      chk("bp_rsp1_valid", rsp1_valid, 1);
      chk("bp_rsp1_out", rsp1_out, 32'hF800_0000);
      chk("bp_rsp0_valid", rsp0_valid, 0);
      chk("bp_req0_ready", req0_ready, 0);
    end
    step(); rsp1_ready = 1; #1;
    chk("bp_rsp1_valid_last", rsp1_valid, 1);
    chk("bp_req0_ready_last", req0_ready, 0);
    step(); #1;
    chk("bp_after_req0_ready", req0_ready, 1);
    chk("bp_after_rsp1_valid", rsp1_valid, 0);
    step(); req0_valid = 0; #1;
    step(); #1;
    chk("bp_add_rsp0_out", rsp0_out, 2);

    // Reset during EXEC discards the operation
    step();
    req1_valid = 1; req1_in1 = 32'hFF; req1_in2 = 32'h0F; req1_op = 4;
    #1;
    chk("mid_req1_ready", req1_ready, 1);
    step(); req1_valid = 0; rst = 1; #1;
    step(); #1;
    chk("mid_rsp0_valid", rsp0_valid, 0);
    chk("mid_rsp1_valid", rsp1_valid, 0);
    chk("mid_alu_in1", alu_in1, 0);

    // Pointer favours req0 after reset; req0 carries illegal opcode 9
    rst = 0;
    req0_valid = 1; req0_in1 = 1; req0_in2 = 1; req0_op = 9;
    req1_valid = 1;
    #1;
    chk("mid_req0_ready", req0_ready, 1);
    chk("mid_req1_ready", req1_ready, 0);
    step(); req0_valid = 0; req1_valid = 0; #1;
    chk("ill_alu_op", alu_alucon, 9);
    chk("mid_rsp1_valid_exec", rsp1_valid, 0);
    step(); #1;
    chk("ill_rsp0_valid", rsp0_valid, 1);
    chk("ill_rsp0_out", rsp0_out, 0);
    chk("ill_rsp0_zero", rsp0_zero, 1);
    chk("ill_rsp1_valid", rsp1_valid, 0);
    step();

    // Back-to-back: accepts every third cycle, result k is 100+3k
    begin
      int k;
      k = 0;
      req0_valid = 1; req0_op = 0; rsp0_ready = 1;
      for (int c = 0; c < 18; c++) begin
        req0_in1 = 100 + k;
        req0_in2 = 2 * k;
        #1;
        chk("b2b_req0_ready", req0_ready, (c % 3 == 0) ? 1 : 0);
        chk("b2b_rsp0_valid", rsp0_valid, (c % 3 == 2) ? 1 : 0);
        if (c % 3 == 2) chk("b2b_rsp0_out", rsp0_out, 100 + 3 * (c / 3));
        if (c % 3 == 0) k++;
        step();
      end
      req0_valid = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
